// File: rtl/serial_add_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl
// Purpose  : Two-requester serial adder controller. Arbitrates round-robin
//            between two requesters, then walks the operands one nibble per
//            cycle through an external 4-bit adder, rippling the carry
//            through an internal register. It presents the full sum and
//            carry-out with a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
  parameter int NIB = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_req0,
  input  logic               i_req1,
  input  logic [4*NIB-1:0]   i_a0,
  input  logic [4*NIB-1:0]   i_b0,
  input  logic [4*NIB-1:0]   i_a1,
  input  logic [4*NIB-1:0]   i_b1,
  input  logic               i_cin0,
  input  logic               i_cin1,
  output logic               o_gnt0,
  output logic               o_gnt1,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_done_id,
  output logic [4*NIB-1:0]   o_sum,
  output logic               o_cout,
  output logic [3:0]         o_add_a,
  output logic [3:0]         o_add_b,
  output logic               o_add_cin,
  input  logic [3:0]         i_add_sum,
  input  logic               i_add_cout
);

  localparam int c_W  = 4 * NIB;
  localparam int c_IW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [c_IW-1:0] c_LAST = c_IW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [c_W-1:0]     r_a;
  logic [c_W-1:0]     r_b;
  logic               r_cin;
  logic [c_IW-1:0]    r_idx;
  logic               r_carry;
  logic [c_W-1:0]     r_acc;
  logic [c_W-1:0]     r_sum;
  logic               r_cout;
  logic               r_done_id;
  logic               r_id;
  logic               r_last;
  logic               r_gnt0;
  logic               r_gnt1;

  logic               w_start;
  logic               w_run;
  logic               w_last_nib;
  logic               w_win;
  logic [c_W-1:0]     w_a;
  logic [c_W-1:0]     w_b;
  logic               w_cin;
  logic [c_W-1:0]     w_acc_next;
  logic [c_IW+1:0]    w_bit_base;

  // Round-robin winner: a lone request wins; on a tie the requester that was
  // not served last wins (r_last = 1 means requester 1 was served last).
  always_comb begin
    w_win = i_req1;
    if (i_req0 && i_req1) begin
      w_win = ~r_last;
    end
    w_a   = w_win ? i_a1   : i_a0;
    w_b   = w_win ? i_b1   : i_b0;
    w_cin = w_win ? i_cin1 : i_cin0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and the nibble-adder drive; adder inputs are zero
  // outside RUN.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_run        = 1'b0;
    w_last_nib   = 1'b0;
    w_bit_base   = {r_idx, 2'b00};
    o_add_a      = 4'd0;
    o_add_b      = 4'd0;
    o_add_cin    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req0 || i_req1) begin
          w_start      = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        w_run     = 1'b1;
        o_add_a   = r_a[w_bit_base +: 4];
        o_add_b   = r_b[w_bit_base +: 4];
        o_add_cin = (r_idx == '0) ? r_cin : r_carry;
        if (r_idx == c_LAST) begin
          w_last_nib   = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Accumulator with the current adder nibble merged in; on the last nibble
  // this is the complete sum.
  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[w_bit_base +: 4] = i_add_sum;
  end

  // Grant pulses and arbitration history.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      r_last <= 1'b1;
      r_id   <= 1'b0;
    end else begin
      r_gnt0 <= w_start & ~w_win;
      r_gnt1 <= w_start &  w_win;
      if (w_start) begin
        r_last <= w_win;
        r_id   <= w_win;
      end
    end
  end

  // Operand capture at grant, then per-nibble accumulation and carry ripple.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_cin   <= 1'b0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_acc   <= '0;
    end else if (w_start) begin
      r_a     <= w_a;
      r_b     <= w_b;
      r_cin   <= w_cin;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_acc   <= '0;
    end else if (w_run) begin
      r_acc   <= w_acc_next;
      r_carry <= i_add_cout;
      r_idx   <= w_last_nib ? '0 : r_idx + c_IW'(1);
    end
  end

  // Visible result only changes on completion, so partial sums never show.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_done_id <= 1'b0;
    end else if (w_last_nib) begin
      r_sum     <= w_acc_next;
      r_cout    <= i_add_cout;
      r_done_id <= r_id;
    end
  end

  assign o_gnt0    = r_gnt0;
  assign o_gnt1    = r_gnt1;
  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = (r_state == S_DONE);
  assign o_done_id = r_done_id;
  assign o_sum     = r_sum;
  assign o_cout    = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_ctrl
// Purpose  : Self-checking bench for serial_add_ctrl with a behavioural
//            external 4-bit adder and a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         id;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         cin0, cin1;
  logic         gnt0, gnt1, busy, done, done_id, cout;
  logic [W-1:0] sum;
  logic [3:0]   add_a, add_b, add_sum;
  logic         add_cin, add_cout;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  bit   chk_en = 1'b0;
  exp_t q[$];

  logic         prev_done = 1'b0;
  logic [W-1:0] prev_sum  = '0;

  serial_add_ctrl #(.NIB(NIB)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req0     (req0),
    .i_req1     (req1),
    .i_a0       (a0),
    .i_b0       (b0),
    .i_a1       (a1),
    .i_b1       (b1),
    .i_cin0     (cin0),
    .i_cin1     (cin1),
    .o_gnt0     (gnt0),
    .o_gnt1     (gnt1),
    .o_busy     (busy),
    .o_done     (done),
    .o_done_id  (done_id),
    .o_sum      (sum),
    .o_cout     (cout),
    .o_add_a    (add_a),
    .o_add_b    (add_b),
    .o_add_cin  (add_cin),
    .i_add_sum  (add_sum),
    .i_add_cout (add_cout)
  );

  // External 4-bit adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input bit id, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic ci);
    logic [W:0] t;
    exp_t e;
    t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    e.sum  = t[W-1:0];
    e.cout = t[W];
    e.id   = id;
    return e;
  endfunction

  // Scoreboard: every done pulse pops and compares the oldest expectation.
  always @(negedge clk) begin
    if (chk_en && done === 1'b1) begin
      n_chk++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_done: done=%b with no pending result at cycle %0d", done, cyc);
      end else begin
        exp_t e;
        n_pass++;
        e = q.pop_front();
        n_chk++;
        if (sum !== e.sum) $display("FAIL sum: got %h expected %h", sum, e.sum);
        else n_pass++;
        n_chk++;
        if (cout !== e.cout) $display("FAIL cout: got %b expected %b", cout, e.cout);
        else n_pass++;
        n_chk++;
        if (done_id !== e.id) $display("FAIL done_id: got %b expected %b", done_id, e.id);
        else n_pass++;
      end
    end
  end

  // Per-cycle invariants.
  always @(negedge clk) begin
    if (chk_en) begin
      if (!(busy === 1'b1 && done === 1'b0)) begin
        n_chk++;
        if ({add_a, add_b, add_cin} !== 9'd0)
          $display("FAIL add_idle: add_a=%h add_b=%h add_cin=%b expected 0", add_a, add_b, add_cin);
        else n_pass++;
      end
      if (done === 1'b1) begin
        n_chk++;
        if (prev_done === 1'b1) $display("FAIL done_width: done high %b for 2 cycles, expected 1", done);
        else n_pass++;
      end
      if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
        n_chk++;
        if (gnt0 === 1'b1 && gnt1 === 1'b1) $display("FAIL gnt_onehot: gnt0=%b gnt1=%b", gnt0, gnt1);
        else n_pass++;
      end
      if (done !== 1'b1 && sum !== prev_sum && sum !== '0) begin
        n_chk++;
        $display("FAIL sum_stable: sum %h changed from %h without done", sum, prev_sum);
      end
    end
    prev_done = done;
    prev_sum  = sum;
  end

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) for the next grant of either requester.
  task automatic wait_gnt(output bit got, output bit g0, output bit g1, output int c);
    got = 1'b0; g0 = 1'b0; g1 = 1'b0; c = 0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
        got = 1'b1; g0 = gnt0; g1 = gnt1; c = cyc;
      end
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (done === 1'b1) break;
    end
    n_chk++;
    if (done !== 1'b1) $display("FAIL done_timeout: done=%b after %0d cycles", done, lat);
    else n_pass++;
  endtask

  task automatic request(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input bit push);
    bit got, g0, g1;
    int c;
    @(negedge clk);
    if (id) begin a1 = a; b1 = b; cin1 = ci; req1 = 1'b1; end
    else    begin a0 = a; b0 = b; cin0 = ci; req0 = 1'b1; end
    if (push) q.push_back(model(id, a, b, ci));
    wait_gnt(got, g0, g1, c);
    n_chk++;
    if (!got || (id ? g1 : g0) !== 1'b1)
      $display("FAIL gnt_req%0d: got gnt0=%b gnt1=%b expected gnt%0d", id, g0, g1, id);
    else n_pass++;
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 0; req1 = 0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; cin0 = 0; cin1 = 0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({sum, cout, done, done_id, busy, gnt0, gnt1} !== '0)
      $display("FAIL reset_outputs: sum=%h cout=%b done=%b id=%b busy=%b gnt=%b%b expected all 0",
               sum, cout, done, done_id, busy, gnt0, gnt1);
    else n_pass++;
    n_chk++;
    if ({add_a, add_b, add_cin} !== 9'd0)
      $display("FAIL reset_adder: add_a=%h add_b=%h cin=%b expected 0", add_a, add_b, add_cin);
    else n_pass++;
    chk_en = 1'b1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    request(1'b0, 16'h1234, 16'h4321, 1'b0, 1'b1);
    wait_done(lat);
    n_chk++;
    if (lat != NIB) $display("FAIL latency: done %0d cycles after gnt, expected %0d", lat, NIB);
    else n_pass++;
    n_chk++;
    if (sum !== 16'h5555) $display("FAIL basic_sum: got %h expected 5555", sum);
    else n_pass++;
  endtask

  task automatic test_carry();
    int lat;
    request(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    wait_done(lat);
    n_chk++;
    if ({cout, sum} !== 17'h10000) $display("FAIL ripple: got %b_%h expected 1_0000", cout, sum);
    else n_pass++;
    request(1'b1, 16'h000F, 16'h0000, 1'b1, 1'b1);
    wait_done(lat);
  endtask

  task automatic test_random();
    int lat;
    for (int i = 0; i < 8; i++) begin
      request(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b1);
      wait_done(lat);
    end
  endtask

  task automatic test_tie();
    bit got, g0, g1;
    int c1, c2, lat;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      a0 = 16'h1111 * (r + 1); b0 = 16'h0F0F; cin0 = 1'b0;
      a1 = 16'h2222 * (r + 1); b1 = 16'hF0F0; cin1 = 1'b1;
      q.push_back(model(1'b0, a0, b0, cin0));
      q.push_back(model(1'b1, a1, b1, cin1));
      req0 = 1'b1; req1 = 1'b1;
      wait_gnt(got, g0, g1, c1);
      n_chk++;
      if (!got || g0 !== 1'b1) $display("FAIL tie_first: gnt0=%b gnt1=%b expected gnt0", g0, g1);
      else n_pass++;
      req0 = 1'b0;
      wait_gnt(got, g0, g1, c2);
      n_chk++;
      if (!got || g1 !== 1'b1) $display("FAIL tie_second: gnt0=%b gnt1=%b expected gnt1", g0, g1);
      else n_pass++;
      n_chk++;
      if (c2 - c1 != NIB + 2) $display("FAIL tie_spacing: got %0d expected %0d", c2 - c1, NIB + 2);
      else n_pass++;
      req1 = 1'b0;
      wait_done(lat);
    end
  endtask

  task automatic test_back_to_back();
    int  ids[4];
    int  cs[4];
    int  n = 0;
    int  busy_low = 0;
    int  lat;
    do_reset();
    @(negedge clk);
    a0 = 16'hABCD; b0 = 16'h1357; cin0 = 1'b1;
    a1 = 16'h8000; b1 = 16'h8000; cin1 = 1'b0;
    for (int k = 0; k < 4; k++) q.push_back(model(1'(k % 2), k % 2 ? a1 : a0, k % 2 ? b1 : b0, k % 2 ? cin1 : cin0));
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 80 && n < 4; k++) begin
      @(negedge clk);
      if (n >= 1 && busy !== 1'b1) busy_low++;
      if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
        ids[n] = gnt1 ? 1 : 0;
        cs[n]  = cyc;
        n++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    n_chk++;
    if (n != 4) $display("FAIL b2b_count: got %0d grants expected 4", n);
    else begin
      n_pass++;
      for (int k = 0; k < 4; k++) begin
        n_chk++;
        if (ids[k] != k % 2) $display("FAIL b2b_order: grant %0d went to %0d expected %0d", k, ids[k], k % 2);
        else n_pass++;
      end
      for (int k = 1; k < 4; k++) begin
        n_chk++;
        if (cs[k] - cs[k-1] != NIB + 2)
          $display("FAIL b2b_spacing: gap %0d expected %0d", cs[k] - cs[k-1], NIB + 2);
        else n_pass++;
      end
      n_chk++;
      if (busy_low != 3) $display("FAIL b2b_busy_gap: busy low %0d cycles expected 3", busy_low);
      else n_pass++;
    end
    wait_done(lat);
  endtask

  task automatic test_reset_abort();
    int lat;
    request(1'b0, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if ({cout, sum} !== '0) $display("FAIL abort_result: got %b_%h expected 0_0000", cout, sum);
    else n_pass++;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_state: busy=%b done=%b expected 0 0", busy, done);
    else n_pass++;
    repeat (NIB + 3) @(negedge clk);
    request(1'b0, 16'h0102, 16'h0304, 1'b1, 1'b1);
    wait_done(lat);
    n_chk++;
    if (sum !== 16'h0407) $display("FAIL abort_fresh: got %h expected 0407", sum);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_random();
    test_tie();
    test_back_to_back();
    test_reset_abort();
    repeat (3) @(negedge clk);
    n_chk++;
    if (q.size() != 0) $display("FAIL scoreboard_drain: %0d results pending expected 0", q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
